// File: rtl/wm_pkg.sv
// Shared definitions for the washing machine controller:
// state codes and default phase durations.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_FILL  = 3'b001,
    ST_WASH  = 3'b010,
    ST_RINSE = 3'b011,
    ST_SPIN  = 3'b100,
    ST_DONE  = 3'b101
  } state_t;

  localparam int unsigned FILL_CYCLES_D  = 3;
  localparam int unsigned WASH_CYCLES_D  = 6;
  localparam int unsigned RINSE_CYCLES_D = 4;
  localparam int unsigned SPIN_CYCLES_D  = 3;
  localparam int unsigned DONE_CYCLES_D  = 2;
  localparam int unsigned TIMER_W_D      = 8;

endpackage

// File: rtl/wm_phase_timer.sv
// Phase timer: counts cycles spent in the current state.
// Ports: clk, reset (sync, active-low), clear, length -> expired.
module wm_phase_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [TIMER_W-1:0] length,
  output logic               expired
);

  localparam logic [TIMER_W-1:0] ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic [TIMER_W-1:0] cnt;

  // expired marks the last cycle of the phase. A length of
  // 2**TIMER_W truncates to 0, and 0-1 is all-ones, so the
  // full range still works.
  assign expired = (cnt == (length - ONE));

  // Saturates on the last count so it never wraps.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/washing_machine_ctrl.sv
// Washing machine sequencer: IDLE->FILL->WASH->RINSE->SPIN->DONE.
// Ports: clk, reset, start, stop -> actuators, done, state code.
module washing_machine_ctrl
  import wm_pkg::*;
#(
  parameter int unsigned FILL_CYCLES  = FILL_CYCLES_D,
  parameter int unsigned WASH_CYCLES  = WASH_CYCLES_D,
  parameter int unsigned RINSE_CYCLES = RINSE_CYCLES_D,
  parameter int unsigned SPIN_CYCLES  = SPIN_CYCLES_D,
  parameter int unsigned DONE_CYCLES  = DONE_CYCLES_D,
  parameter int unsigned TIMER_W      = TIMER_W_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  output logic       fill_valve,
  output logic       motor,
  output logic       drain_valve,
  output logic       soap_dispenser,
  output logic       done,
  output logic [2:0] state
);

  state_t             cur;
  state_t             nxt;
  logic               expired;
  logic               clear;
  logic [TIMER_W-1:0] len;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur <= ST_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    if (stop) begin
      nxt = ST_IDLE;
    end else begin
      unique case (cur)
        ST_IDLE:  if (start)   nxt = ST_FILL;
        ST_FILL:  if (expired) nxt = ST_WASH;
        ST_WASH:  if (expired) nxt = ST_RINSE;
        ST_RINSE: if (expired) nxt = ST_SPIN;
        ST_SPIN:  if (expired) nxt = ST_DONE;
        ST_DONE:  if (expired) nxt = ST_IDLE;
        default:  nxt = ST_IDLE;
      endcase
    end
  end

  // Timer restarts whenever the state is about to change.
  assign clear = (nxt != cur);

  always_comb begin
    len = TIMER_W'(1);
    unique case (cur)
      ST_FILL:  len = TIMER_W'(FILL_CYCLES);
      ST_WASH:  len = TIMER_W'(WASH_CYCLES);
      ST_RINSE: len = TIMER_W'(RINSE_CYCLES);
      ST_SPIN:  len = TIMER_W'(SPIN_CYCLES);
      ST_DONE:  len = TIMER_W'(DONE_CYCLES);
      default:  len = TIMER_W'(1);
    endcase
  end

  wm_phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .length  (len),
    .expired (expired)
  );

  always_comb begin
    fill_valve     = 1'b0;
    motor          = 1'b0;
    drain_valve    = 1'b0;
    soap_dispenser = 1'b0;
    done           = 1'b0;
    unique case (cur)
      ST_FILL: begin
        fill_valve = 1'b1;
      end
      ST_WASH: begin
        motor          = 1'b1;
        soap_dispenser = 1'b1;
      end
      ST_RINSE: begin
        motor      = 1'b1;
        fill_valve = 1'b1;
      end
      ST_SPIN: begin
        motor       = 1'b1;
        drain_valve = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Self-checking bench for washing_machine_ctrl:
// vector table, directed corner cases and random stimulus.
module tb_washing_machine_ctrl;

  localparam int F = 3;
  localparam int W = 6;
  localparam int R = 4;
  localparam int S = 3;
  localparam int D = 2;
  localparam int TOTAL = F + W + R + S + D;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       fill_valve;
  logic       motor;
  logic       drain_valve;
  logic       soap_dispenser;
  logic       done;
  logic [2:0] state;

  int checks;
  int errors;

  // Reference: a run is just "cycles since FILL entry".
  bit run;
  int age;

  washing_machine_ctrl dut (
    .clk            (clk),
    .reset          (rst),
    .start          (start),
    .stop           (stop),
    .fill_valve     (fill_valve),
    .motor          (motor),
    .drain_valve    (drain_valve),
    .soap_dispenser (soap_dispenser),
    .done           (done),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_code();
    if (!run) return 3'd0;
    if (age < F) return 3'd1;
    if (age < F + W) return 3'd2;
    if (age < F + W + R) return 3'd3;
    if (age < F + W + R + S) return 3'd4;
    return 3'd5;
  endfunction

  // {fill, motor, drain, soap, done}
  function automatic logic [4:0] outs_of(logic [2:0] c);
    case (c)
      3'd1:    return 5'b10000;
      3'd2:    return 5'b01010;
      3'd3:    return 5'b11000;
      3'd4:    return 5'b01100;
      3'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] dut_outs();
    return {fill_valve, motor, drain_valve, soap_dispenser, done};
  endfunction

  task automatic model_edge(bit r, bit st, bit sp);
    if (!r || sp) begin
      run = 0;
      age = 0;
    end else if (!run) begin
      if (st) begin
        run = 1;
        age = 0;
      end
    end else begin
      age++;
      if (age >= TOTAL) begin
        run = 0;
        age = 0;
      end
    end
  endtask

  task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, model at posedge, check after.
  task automatic step(bit r, bit st, bit sp);
    @(negedge clk);
    rst   = r;
    start = st;
    stop  = sp;
    @(posedge clk);
    model_edge(r, st, sp);
    #1;
    chk("state", {2'b00, state}, {2'b00, ref_code()});
    chk("outs", dut_outs(), outs_of(ref_code()));
  endtask

  typedef struct {
    bit         r;
    bit         st;
    bit         sp;
    logic [2:0] exp_state;
    logic [4:0] exp_outs;
  } vec_t;

  vec_t vecs[13];
  int   fill_cnt;
  int   fill_entries;
  logic [2:0] prev;

  initial begin
    checks = 0;
    errors = 0;
    run    = 0;
    age    = 0;
    rst    = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;

    vecs[0]  = '{0, 1, 0, 3'd0, 5'b00000};
    vecs[1]  = '{1, 0, 0, 3'd0, 5'b00000};
    vecs[2]  = '{1, 0, 0, 3'd0, 5'b00000};
    vecs[3]  = '{1, 1, 0, 3'd1, 5'b10000};
    vecs[4]  = '{1, 0, 0, 3'd1, 5'b10000};
    vecs[5]  = '{1, 0, 0, 3'd1, 5'b10000};
    vecs[6]  = '{1, 0, 0, 3'd2, 5'b01010};
    vecs[7]  = '{1, 0, 1, 3'd0, 5'b00000};
    vecs[8]  = '{1, 1, 1, 3'd0, 5'b00000};
    vecs[9]  = '{1, 1, 0, 3'd1, 5'b10000};
    vecs[10] = '{1, 1, 0, 3'd1, 5'b10000};
    vecs[11] = '{1, 1, 0, 3'd1, 5'b10000};
    vecs[12] = '{1, 1, 0, 3'd2, 5'b01010};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst   = vecs[i].r;
      start = vecs[i].st;
      stop  = vecs[i].sp;
      @(posedge clk);
      model_edge(vecs[i].r, vecs[i].st, vecs[i].sp);
      #1;
      chk($sformatf("vec%0d_state", i), {2'b00, state},
          {2'b00, vecs[i].exp_state});
      chk($sformatf("vec%0d_outs", i), dut_outs(),
          vecs[i].exp_outs);
    end

    // No start for 5 cycles after reset.
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("idle_hold", {2'b00, state}, 5'd0);

    // Full normal cycle, counting time spent in each state.
    step(1, 1, 0);
    begin
      int dur[6];
      for (int k = 0; k < 6; k++) dur[k] = 0;
      dur[state]++;
      for (int i = 0; i < TOTAL + 2; i++) begin
        step(1, 0, 0);
        if (state < 3'd6) dur[state]++;
      end
      chk("dur_fill", 5'(dur[1]), 5'(F));
      chk("dur_wash", 5'(dur[2]), 5'(W));
      chk("dur_rinse", 5'(dur[3]), 5'(R));
      chk("dur_spin", 5'(dur[4]), 5'(S));
      chk("dur_done", 5'(dur[5]), 5'(D));
    end

    // Stop one cycle after entering each active phase.
    for (int p = 1; p <= 4; p++) begin
      int skip;
      skip = (p == 1) ? 0 : (p == 2) ? F :
             (p == 3) ? F + W : F + W + R;
      step(0, 0, 0);
      step(1, 1, 0);
      for (int i = 0; i < skip + 1; i++) step(1, 0, 0);
      chk($sformatf("pre_stop%0d", p), {2'b00, state}, 5'(p));
      step(1, 0, 1);
      chk($sformatf("stop%0d", p),
          {state, fill_valve, motor}, 5'b0);
      step(1, 1, 0);
      chk($sformatf("restart%0d", p), {2'b00, state}, 5'd1);
    end

    // Reset pulse in the middle of RINSE.
    step(0, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < F + W + 1; i++) step(1, 0, 0);
    chk("pre_rst_rinse", {2'b00, state}, 5'd3);
    step(0, 0, 0);
    chk("rst_rinse", dut_outs(), 5'b0);
    step(1, 1, 0);
    for (int i = 0; i < F - 1; i++) step(1, 0, 0);
    chk("rst_timer_fill", {2'b00, state}, 5'd1);
    step(1, 0, 0);
    chk("rst_timer_wash", {2'b00, state}, 5'd2);

    // Repeated start presses: one FILL entry lasting F cycles.
    step(0, 0, 0);
    step(1, 0, 0);
    fill_cnt     = 0;
    fill_entries = 0;
    prev         = state;
    for (int i = 0; i < 8; i++) begin
      bit s;
      s = (i == 0 || i == 2);
      step(1, s, 0);
      if (state == 3'd1) fill_cnt++;
      if (state == 3'd1 && prev != 3'd1) fill_entries++;
      prev = state;
    end
    chk("multi_fill_len", 5'(fill_cnt), 5'(F));
    chk("multi_fill_ent", 5'(fill_entries), 5'd1);

    // Random stimulus against the reference.
    step(0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit r, st, sp;
      r  = ($urandom_range(0, 49) != 0);
      sp = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 3) == 0);
      step(r, st, sp);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
